// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// Holds the FSM state enum, opcode constants, ALU operation codes and
// datapath select encodings. Imported by alu_decoder and multicycle_controller.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_JUMP_PC,
    S_LUI, S_AUIPC, S_HALT
  } state_t;

  // Which family of ALU operation the current state needs.
  typedef enum logic [1:0] {CLS_ADD, CLS_R, CLS_I, CLS_BR} alu_class_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [2:0] RES_ALUOUT = 3'd0;
  localparam logic [2:0] RES_MEM    = 3'd1;
  localparam logic [2:0] RES_PC4    = 3'd2;
  localparam logic [2:0] RES_IMM    = 3'd3;
  localparam logic [2:0] RES_RET    = 3'd4;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decoder.
// Ports: alu_class (operation family requested by the FSM), funct3,
// funct7_b5 (bit 5 of funct7) -> alu_control (ALU operation code).
module alu_decoder
  import ctrl_pkg::*;
(
  input  alu_class_t  alu_class,
  input  logic [2:0]  funct3,
  input  logic        funct7_b5,
  output logic [3:0]  alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_class)
      CLS_R, CLS_I: begin
        case (funct3)
          // funct7[5] selects SUB only for register ops; ADDI has no SUB form.
          3'b000: alu_control = (alu_class == CLS_R && funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b001: alu_control = ALU_SLL;
          3'b010: alu_control = ALU_SLT;
          3'b011: alu_control = ALU_SLTU;
          3'b100: alu_control = ALU_XOR;
          3'b101: alu_control = funct7_b5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_control = ALU_OR;
          3'b111: alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      CLS_BR: begin
        case (funct3[2:1])
          2'b00:   alu_control = ALU_SUB;
          2'b10:   alu_control = ALU_SLT;
          2'b11:   alu_control = ALU_SLTU;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM (Moore outputs; branch PC_write is the
// only output that also depends on the live ALU flags).
// Ports: clk, reset (sync, active-high); op_code/funct3/funct7 of the
// latched instruction; Zero/ALUResultLSB live ALU flags; datapath enables
// adr_src, mem_write, IR_write, reg_write, PC_write; selects result_src,
// alu_src_a, alu_src_b, imm_src; alu_control.
// Build option ILLEGAL_TRAP_EN: adds output illegal_instr and a HALT state
// entered on an unknown opcode or branch funct3 010/011; held until reset.
// Without it, unknown opcodes retire as a NOP.
//
// state       | meaning
// FETCH       | read instruction, PC <= PC+4
// DECODE      | precompute old PC + imm (branch/jump target)
// MEM_ADR     | rs1 + imm address for load/store
// MEM_READ    | present address to memory
// MEM_WB      | write load data to rd
// MEM_WRITE   | store rs2 to memory
// EXEC_R/I    | register / immediate ALU operation
// ALU_WB      | write ALU result to rd
// BRANCH      | compare rs1/rs2, PC <= target when taken
// JAL/JALR    | rd <= return address, compute target
// JUMP_PC     | PC <= target
// LUI/AUIPC   | upper-immediate forms
// HALT        | illegal instruction trap (option only)
module multicycle_controller
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op_code,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  input  logic       ALUResultLSB,
  output logic       adr_src,
  output logic       mem_write,
  output logic       IR_write,
  output logic       reg_write,
  output logic       PC_write,
  output logic [2:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       illegal_instr
`endif
);

  state_t     state, state_next;
  alu_class_t alu_class;
  logic [3:0] alu_dec;
  logic       branch_taken;
  logic       unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    case (state)
      S_EXEC_R: alu_class = CLS_R;
      S_EXEC_I: alu_class = CLS_I;
      S_BRANCH: alu_class = CLS_BR;
      default:  alu_class = CLS_ADD;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_class   (alu_class),
    .funct3      (funct3),
    .funct7_b5   (funct7[5]),
    .alu_control (alu_dec)
  );

  assign alu_control = reset ? ALU_ADD : alu_dec;

  always_comb begin
    case (funct3)
      3'b000:         branch_taken = Zero;
      3'b001:         branch_taken = !Zero;
      3'b100, 3'b110: branch_taken = ALUResultLSB;
      3'b101, 3'b111: branch_taken = !ALUResultLSB;
      default:        branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    IR_write   = 1'b0;
    reg_write  = 1'b0;
    PC_write   = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    imm_src    = IMM_I;
    case (state)
      S_FETCH: begin
        IR_write   = 1'b1;
        PC_write   = 1'b1;
        result_src = RES_PC4;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        if (op_code == OP_BRANCH)   imm_src = IMM_B;
        else if (op_code == OP_JAL) imm_src = IMM_J;
        case (op_code)
          OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
          OP_R:              state_next = S_EXEC_R;
          OP_I:              state_next = S_EXEC_I;
`ifdef ILLEGAL_TRAP_EN
          OP_BRANCH:         state_next = (funct3[2:1] == 2'b01) ? S_HALT : S_BRANCH;
`else
          OP_BRANCH:         state_next = S_BRANCH;
`endif
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_AUIPC;
`ifdef ILLEGAL_TRAP_EN
          default:           state_next = S_HALT;
`else
          default:           state_next = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        imm_src    = (op_code == OP_STORE) ? IMM_S : IMM_I;
        state_next = (op_code == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        adr_src    = 1'b1;
        state_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_WRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a  = SRCA_RS1;
        state_next = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        state_next = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        PC_write   = branch_taken;
        state_next = S_FETCH;
      end
      // ALU keeps old PC + J-immediate so ALU_out holds the target.
      S_JAL: begin
        reg_write  = 1'b1;
        result_src = RES_RET;
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_J;
        state_next = S_JUMP_PC;
      end
      // Target is registered in ALU_out this cycle, so rd == rs1 is harmless.
      S_JALR: begin
        reg_write  = 1'b1;
        result_src = RES_RET;
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        state_next = S_JUMP_PC;
      end
      S_JUMP_PC: begin
        PC_write   = 1'b1;
        state_next = S_FETCH;
      end
      S_LUI: begin
        imm_src    = IMM_U;
        result_src = RES_IMM;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_AUIPC: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_U;
        state_next = S_ALU_WB;
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
    if (reset) begin
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      IR_write   = 1'b0;
      reg_write  = 1'b0;
      PC_write   = 1'b0;
      result_src = RES_ALUOUT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      imm_src    = IMM_I;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  assign illegal_instr = (state == S_HALT) && !reset;
`endif

endmodule
